// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, single-outstanding imem request,
// in-order instruction FIFO feeding decode, branch redirect with discard.
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_instr,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [63:0] dec_pc,
    output logic [10:0] dec_opcode
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] L_DEPTH = (CW+1)'(DEPTH);
    localparam logic [CW:0] L_ONE   = (CW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISC
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [63:0]   r_pc;
    logic [63:0]   w_pc_nxt;
    logic [63:0]   r_req_addr;
    logic [63:0]   w_req_nxt;
    logic [AW-1:0] r_head;
    logic [CW-1:0] r_count;
    logic [31:0]   r_instr [DEPTH];
    logic [63:0]   r_ipc   [DEPTH];

    logic          w_pop;
    logic          w_push;
    logic [AW-1:0] w_tail;
    logic [CW:0]   w_left;
    logic          w_room_idle;
    logic          w_room_push;
    logic [63:0]   w_tgt;
    logic          w_unused_tgt;

    assign w_tgt        = {br_target[63:2], 2'b00};
    assign w_unused_tgt = &{1'b0, br_target[1:0]};

    assign dec_valid  = (r_count != '0);
    assign dec_instr  = dec_valid ? r_instr[r_head] : NOP_INSTR;
    assign dec_pc     = dec_valid ? r_ipc[r_head] : 64'h0;
    assign dec_opcode = dec_instr[31:21];

    assign imem_req  = (r_state != S_IDLE);
    assign imem_addr = r_req_addr;

    assign w_pop  = dec_valid & ~stall & ~br_taken;
    assign w_tail = r_head + r_count[AW-1:0];

    // Issue reserves a FIFO slot, so the response can never overflow.
    assign w_left      = {1'b0, r_count} - (CW+1)'(w_pop);
    assign w_room_idle = (w_left < L_DEPTH);
    assign w_room_push = ((w_left + L_ONE) < L_DEPTH);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_req_nxt   = r_req_addr;
        w_push      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (br_taken) begin
                    w_pc_nxt = w_tgt;
                end else if (w_room_idle) begin
                    w_req_nxt   = r_pc;
                    w_pc_nxt    = r_pc + 64'd4;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (br_taken) begin
                    w_pc_nxt    = w_tgt;
                    w_state_nxt = imem_valid ? S_IDLE : S_DISC;
                end else if (imem_valid) begin
                    w_push = 1'b1;
                    if (w_room_push) begin
                        w_req_nxt = r_pc;
                        w_pc_nxt  = r_pc + 64'd4;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DISC: begin
                if (br_taken) begin
                    w_pc_nxt = w_tgt;
                end
                if (imem_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_req_addr <= 64'h0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req_addr <= w_req_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_count <= '0;
        end else if (br_taken) begin
            r_head  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Payload needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[w_tail] <= imem_instr;
            r_ipc[w_tail]   <= r_req_addr;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, multi-cycle corner
// sequences and a randomized run against an in-order stream model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        br_taken;
    logic [63:0] br_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_instr;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [63:0] dec_pc;
    logic [10:0] dec_opcode;

    int n_chk  = 0;
    int n_pass = 0;
    int lat    = 1;
    logic [3:0] mcnt;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (64'h0),
        .DEPTH    (2),
        .NOP_INSTR(32'hD503201F)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_valid(imem_valid),
        .imem_instr(imem_instr),
        .dec_valid (dec_valid),
        .dec_instr (dec_instr),
        .dec_pc    (dec_pc),
        .dec_opcode(dec_opcode)
    );

    // Memory model: answers after `lat` cycles of a pending request.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) mcnt <= '0;
        else if (imem_req && !imem_valid) mcnt <= mcnt + 4'd1;
        else mcnt <= '0;
    end
    assign imem_valid = imem_req && (int'(mcnt) >= lat - 1);
    assign imem_instr = imem_addr[31:0] | 32'h8B000000;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_dec(input string tag, input logic ev,
                           input logic [63:0] epc);
        logic [31:0] ei;
        ei = ev ? (epc[31:0] | 32'h8B000000) : NOP;
        chk({tag, "_valid"}, 64'(dec_valid), 64'(ev));
        chk({tag, "_pc"}, dec_pc, ev ? epc : 64'h0);
        chk({tag, "_instr"}, 64'(dec_instr), 64'(ei));
        chk({tag, "_opc"}, 64'(dec_opcode), 64'(ei[31:21]));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = 64'h0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [63:0] tgt;
        logic        ereq;
        logic [63:0] eaddr;
        logic        ev;
        logic [63:0] epc;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [63:0] exp_pc;
        logic [63:0] prev_addr;
        logic        prev_pend;
        int          pops;
        int          k;

        tbl[0]  = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h00, 1'b0, 64'h00};
        tbl[1]  = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h04, 1'b1, 64'h00};
        tbl[2]  = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h08, 1'b1, 64'h04};
        tbl[3]  = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h0C, 1'b1, 64'h08};
        tbl[4]  = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h10, 1'b1, 64'h0C};
        tbl[5]  = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h10, 1'b1, 64'h0C};
        tbl[6]  = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h10, 1'b1, 64'h0C};
        tbl[7]  = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h10, 1'b1, 64'h0C};
        tbl[8]  = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h10, 1'b1, 64'h0C};
        tbl[9]  = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h10, 1'b1, 64'h0C};
        tbl[10] = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h14, 1'b1, 64'h10};
        tbl[11] = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h18, 1'b1, 64'h14};
        tbl[12] = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h1C, 1'b1, 64'h18};

        // Reset state and streaming/stall vectors
        lat = 1;
        do_reset();
        chk("rst_req", 64'(imem_req), 64'h0);
        chk("rst_addr", imem_addr, 64'h0);
        chk_dec("rst", 1'b0, 64'h0);
        for (int i = 0; i < 13; i++) begin
            stall     = tbl[i].stall;
            br_taken  = tbl[i].br;
            br_target = tbl[i].tgt;
            step();
            chk($sformatf("v%0d_req", i), 64'(imem_req), 64'(tbl[i].ereq));
            chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].eaddr);
            chk_dec($sformatf("v%0d", i), tbl[i].ev, tbl[i].epc);
        end

        // Redirect while a slow request is outstanding
        lat = 3;
        do_reset();
        step();
        chk("br_issue_addr", imem_addr, 64'h0);
        br_taken  = 1'b1;
        br_target = 64'h103;
        step();
        br_taken = 1'b0;
        chk("br_disc_req", 64'(imem_req), 64'h1);
        chk("br_disc_addr", imem_addr, 64'h0);
        k = 0;
        while (!(imem_req && imem_addr != 64'h0) && !dec_valid && k < 20) begin
            step();
            k++;
        end
        chk("br_new_addr", imem_addr, 64'h100);
        k = 0;
        while (!dec_valid && k < 20) begin
            step();
            k++;
        end
        chk_dec("br_first", 1'b1, 64'h100);

        // Flush coinciding with a response, FIFO reserved full, stall held
        lat = 3;
        do_reset();
        stall = 1'b1;
        k = 0;
        while (!dec_valid && k < 20) begin
            step();
            k++;
        end
        k = 0;
        while (!imem_valid && k < 20) begin
            step();
            k++;
        end
        chk("fl_resp", 64'(imem_valid), 64'h1);
        chk_dec("fl_pre", 1'b1, 64'h0);
        br_taken  = 1'b1;
        br_target = 64'h200;
        step();
        br_taken = 1'b0;
        chk_dec("fl_post", 1'b0, 64'h0);
        chk("fl_idle", 64'(imem_req), 64'h0);
        stall = 1'b0;
        step();
        chk("fl_reissue", {63'h0, imem_req}, 64'h1);
        chk("fl_addr", imem_addr, 64'h200);

        // PC wrap at the top of the address space
        lat = 1;
        do_reset();
        br_taken  = 1'b1;
        br_target = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        br_taken = 1'b0;
        chk("wr_idle", 64'(imem_req), 64'h0);
        step();
        chk("wr_addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("wr_addr1", imem_addr, 64'h0);
        chk_dec("wr_top", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk_dec("wr_zero", 1'b1, 64'h0);

        // Asynchronous reset in the middle of an outstanding request
        lat = 3;
        do_reset();
        stall = 1'b1;
        k = 0;
        while (!dec_valid && k < 20) begin
            step();
            k++;
        end
        step();
        chk("ar_pre_req", 64'(imem_req), 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_req", 64'(imem_req), 64'h0);
        chk("ar_addr", imem_addr, 64'h0);
        chk_dec("ar", 1'b0, 64'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        stall   = 1'b0;
        lat     = 1;
        step();
        chk("ar_restart_req", 64'(imem_req), 64'h1);
        chk("ar_restart_addr", imem_addr, 64'h0);
        step();
        chk_dec("ar_restart", 1'b1, 64'h0);

        // Randomized run: consumed stream must be the sequential program
        // from reset or from the most recent branch target.
        do_reset();
        exp_pc    = 64'h0;
        prev_pend = 1'b0;
        prev_addr = 64'h0;
        pops      = 0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_pend) begin
                chk("rnd_req_hold", 64'(imem_req), 64'h1);
                chk("rnd_addr_hold", imem_addr, prev_addr);
            end
            if (dec_valid) begin
                chk("rnd_pc", dec_pc, exp_pc);
                chk("rnd_instr", 64'(dec_instr),
                    64'(exp_pc[31:0] | 32'h8B000000));
            end else begin
                chk("rnd_empty_pc", dec_pc, 64'h0);
                chk("rnd_empty_instr", 64'(dec_instr), 64'(NOP));
            end
            stall    = ($urandom_range(0, 99) < 30);
            br_taken = ($urandom_range(0, 99) < 5);
            br_target = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0)
                br_target = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            lat = $urandom_range(1, 3);
            #1;
            if (dec_valid && !stall && !br_taken) begin
                exp_pc = exp_pc + 64'd4;
                pops++;
            end
            if (br_taken) exp_pc = {br_target[63:2], 2'b00};
            prev_pend = imem_req && !imem_valid;
            prev_addr = imem_addr;
            @(posedge clk);
            #1;
        end
        chk("rnd_progress", 64'(pops >= 300), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
